tx_slot_arbiter: RTL and testbench
==================================

// Module: tx_slot_arbiter
// PURPOSE
//  Arbitrates two frame producers (host DMA path, local generator) onto the single write port
//  of the TX frame slot ring consumed by the GMII sender. Whole-frame round-robin grant; frame
//  written at the uncommitted write pointer; mem_wr_ptr advanced only after a complete, well-formed
//  record is in memory. Malformed or oversized records are dropped and counted.
// PARAMETERS
//  MIN_LEN   16'd60    smallest accepted frame_len (bytes, excl. preamble/FCS)
//  MAX_LEN   16'd1514  largest accepted frame_len
//  HDR_WORDS 14'd7     header words per record: len, timestamp[63:0] x4, hash[31:0] x2
// PORTS
//  gmii_tx_clk          in   1   sole clock
//  sys_rst              in   1   asynchronous, active-high reset
//  reqN_valid (N=0,1)   in   1   requester N word valid
//  reqN_data            in   16  word; first word of record = frame_len
//  reqN_sof             in   1   marks first (len) word of record
//  reqN_eof             in   1   marks last word of record
//  reqN_ready           out  1   word accepted when valid&ready
//  mem_rd_ptr           in   14  sender's committed read pointer
//  mem_wr_ptr           out  14  committed write pointer to sender
//  slot_tx_eth_addr     out  14  slot RAM write address
//  slot_tx_eth_data     out  16  slot RAM write data
//  slot_tx_eth_byte_en  out  2   [1]=data[15:8], [0]=data[7:0]
//  slot_tx_eth_wr_en    out  1   slot RAM write strobe
//  grant                out  2   one-hot owner of current record, 0 when idle
//  drop_count           out  16  saturating count of dropped records
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; wr_ptr=0; last_grant=1 (so req0 wins first tie).
//  Record size W = HDR_WORDS + ceil(len/2); free = (mem_rd_ptr - wr_ptr - 1) mod 2^14.
//  States:
//   IDLE : if exactly one reqN_valid&sof -> grant N, LEN. Both -> grant != last_grant.
//          valid words without sof: ready=1, discarded, not counted. reqN_ready=0 otherwise.
//   LEN  : peek granted data (ready=0). len<MIN_LEN or >MAX_LEN -> ready=1 this cycle, DROP
//          (if that word has eof: count drop, IDLE). W<=free -> ready=1, word written at
//          wr_ptr, remaining=W-1, WRITE. W>free -> hold (ready=0) until mem_rd_ptr frees space.
//   WRITE: ready = granted valid; each accepted word written at wr_ptr+idx (mod 2^14).
//          eof with remaining>1 -> truncated: count drop, IDLE, no commit.
//          remaining==1 & eof -> COMMIT. remaining==1 & !eof -> DROP.
//   DROP : ready=1 for granted requester; nothing written; on eof count drop, IDLE.
//   COMMIT: mem_wr_ptr <= wr_ptr + W (mod 2^14); wr_ptr follows; last_grant <= owner; IDLE.
//  Only the granted requester sees ready=1 outside IDLE; other side stalls.
//  Write timing: word accepted cycle t -> wr_en/addr/data registered at t+1.
//  Commit: mem_wr_ptr updates at t+2 after eof accept, i.e. strictly after last RAM write.
//  byte_en=2'b11 on all words except last data word of odd len: 2'b10 (first byte in [15:8]).
//  sof seen outside IDLE/LEN is ignored (treated as data).
//  Pointer wrap: all address arithmetic mod 2^14; record may straddle 0x3FFF->0x0000.
//  Full ring: free=0 holds LEN indefinitely; no writes, no drops.
//  drop_count saturates at 16'hFFFF.
//  Reset mid-record: async clear, partial record never committed, mem_wr_ptr=0.
// TESTING
//  1 req0 len=60 (37 words) eof on word 37, empty ring -> 37 writes at 0x0000..0x0024,
//    mem_wr_ptr=0x0025 two cycles after eof accept, byte_en=11 throughout.
//  2 req0 and req1 sof same cycle after reset, len=61 each -> req0 record first, then req1
//    at 0x0026; req1 last data word byte_en=10; mem_wr_ptr=0x004C.
//  3 wr_ptr=0x3FF0, mem_rd_ptr=0x3FF0, len=64 (39 words) -> addresses wrap to 0x0000..0x0016,
//    mem_wr_ptr=0x0017.
//  4 mem_rd_ptr=wr_ptr+20, len=100 -> ready stays 0 in LEN; raise mem_rd_ptr by 64 -> accepted.
//  5 len=2000 -> no writes, all words until eof consumed, drop_count=1, mem_wr_ptr unchanged;
//    eof on word 10 of len=60 record -> drop_count=2, no commit.
//  6 sys_rst asserted mid-WRITE -> outputs 0 asynchronously; next record written from 0x0000.

Source files
------------

// File: rtl/tx_slot_arbiter.sv
// Two-requester, whole-frame round-robin writer into the TX slot ring.
// Records are committed to mem_wr_ptr only after the final word is in RAM.
module tx_slot_arbiter #(
  parameter logic [15:0] MIN_LEN   = 16'd60,
  parameter logic [15:0] MAX_LEN   = 16'd1514,
  parameter logic [13:0] HDR_WORDS = 14'd7
) (
  input  logic        gmii_tx_clk,
  input  logic        sys_rst,
  input  logic        req0_valid,
  input  logic [15:0] req0_data,
  input  logic        req0_sof,
  input  logic        req0_eof,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_data,
  input  logic        req1_sof,
  input  logic        req1_eof,
  output logic        req1_ready,
  input  logic [13:0] mem_rd_ptr,
  output logic [13:0] mem_wr_ptr,
  output logic [13:0] slot_tx_eth_addr,
  output logic [15:0] slot_tx_eth_data,
  output logic [1:0]  slot_tx_eth_byte_en,
  output logic        slot_tx_eth_wr_en,
  output logic [1:0]  grant,
  output logic [15:0] drop_count
);

  typedef enum logic [2:0] {StIdle, StLen, StWrite, StDrop, StCommit} state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_grant_q, last_grant_d;
  logic [13:0] wr_ptr_q, wr_ptr_d;
  logic [13:0] rec_words_q, rec_words_d;
  logic [13:0] remaining_q, remaining_d;
  logic [13:0] idx_q, idx_d;
  logic        len_odd_q, len_odd_d;
  logic [15:0] drop_q, drop_d;
  logic        we_q, we_d;
  logic [13:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic [1:0]  be_q, be_d;

  logic        g_valid, g_eof, g_ready, drop_inc;
  logic [15:0] g_data;
  logic [16:0] half_len, rec_w17;
  logic [13:0] free_words;
  logic [1:0]  ready_vec;
  logic        sof0, sof1, len_bad;

  assign g_valid    = owner_q ? req1_valid : req0_valid;
  assign g_data     = owner_q ? req1_data  : req0_data;
  assign g_eof      = owner_q ? req1_eof   : req0_eof;
  assign half_len   = ({1'b0, g_data} + 17'd1) >> 1;
  assign rec_w17    = {3'b000, HDR_WORDS} + half_len;
  assign free_words = mem_rd_ptr - wr_ptr_q - 14'd1;
  assign len_bad    = (g_data < MIN_LEN) || (g_data > MAX_LEN);
  assign sof0       = req0_valid & req0_sof;
  assign sof1       = req1_valid & req1_sof;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    wr_ptr_d     = wr_ptr_q;
    rec_words_d  = rec_words_q;
    remaining_d  = remaining_q;
    idx_d        = idx_q;
    len_odd_d    = len_odd_q;
    drop_d       = drop_q;
    we_d         = 1'b0;
    addr_d       = addr_q;
    data_d       = data_q;
    be_d         = be_q;
    ready_vec    = 2'b00;
    g_ready      = 1'b0;
    drop_inc     = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Stray mid-record words are swallowed so a requester can resync on sof.
        ready_vec = {req1_valid & ~req1_sof, req0_valid & ~req0_sof};
        if (sof0 && sof1) begin
          owner_d = ~last_grant_q;
          state_d = StLen;
        end else if (sof0 || sof1) begin
          owner_d = sof1;
          state_d = StLen;
        end
      end
      StLen: begin
        if (g_valid) begin
          if (len_bad) begin
            g_ready = 1'b1;
            if (g_eof) begin
              drop_inc = 1'b1;
              state_d  = StIdle;
            end else begin
              state_d = StDrop;
            end
          end else if (rec_w17 <= {3'b000, free_words}) begin
            g_ready     = 1'b1;
            we_d        = 1'b1;
            addr_d      = wr_ptr_q;
            data_d      = g_data;
            be_d        = 2'b11;
            rec_words_d = rec_w17[13:0];
            remaining_d = rec_w17[13:0] - 14'd1;
            idx_d       = 14'd1;
            len_odd_d   = g_data[0];
            if (g_eof) begin
              drop_inc = 1'b1;
              state_d  = StIdle;
            end else begin
              state_d = StWrite;
            end
          end
        end
      end
      StWrite: begin
        g_ready = g_valid;
        if (g_valid) begin
          we_d        = 1'b1;
          addr_d      = wr_ptr_q + idx_q;
          data_d      = g_data;
          be_d        = (remaining_q == 14'd1 && len_odd_q) ? 2'b10 : 2'b11;
          idx_d       = idx_q + 14'd1;
          remaining_d = remaining_q - 14'd1;
          if (remaining_q == 14'd1) begin
            state_d = g_eof ? StCommit : StDrop;
          end else if (g_eof) begin
            drop_inc = 1'b1;
            state_d  = StIdle;
          end
        end
      end
      StDrop: begin
        g_ready = 1'b1;
        if (g_valid && g_eof) begin
          drop_inc = 1'b1;
          state_d  = StIdle;
        end
      end
      StCommit: begin
        wr_ptr_d     = wr_ptr_q + rec_words_q;
        last_grant_d = owner_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (state_q != StIdle) begin
      ready_vec = owner_q ? {g_ready, 1'b0} : {1'b0, g_ready};
    end
    if (drop_inc && drop_q != 16'hFFFF) begin
      drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge gmii_tx_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      wr_ptr_q     <= '0;
      rec_words_q  <= '0;
      remaining_q  <= '0;
      idx_q        <= '0;
      len_odd_q    <= 1'b0;
      drop_q       <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      be_q         <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      wr_ptr_q     <= wr_ptr_d;
      rec_words_q  <= rec_words_d;
      remaining_q  <= remaining_d;
      idx_q        <= idx_d;
      len_odd_q    <= len_odd_d;
      drop_q       <= drop_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      be_q         <= be_d;
    end
  end

  assign req0_ready          = ready_vec[0];
  assign req1_ready          = ready_vec[1];
  assign mem_wr_ptr          = wr_ptr_q;
  assign slot_tx_eth_addr    = addr_q;
  assign slot_tx_eth_data    = data_q;
  assign slot_tx_eth_byte_en = be_q;
  assign slot_tx_eth_wr_en   = we_q;
  assign drop_count          = drop_q;
  assign grant = (state_q == StIdle) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);

endmodule

// File: tb/tb_tx_slot_arbiter.sv
// Directed bench: drivers push expected RAM writes on acceptance, a monitor
// pops and compares them whenever the DUT strobes slot_tx_eth_wr_en.
module tb_tx_slot_arbiter;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic [1:0]  vld, sof, eof, rdy;
  logic [15:0] dat [2];
  logic [13:0] mem_rd_ptr, mem_wr_ptr, wr_addr;
  logic [15:0] wr_data, drop_count;
  logic [1:0]  wr_be, grant;
  logic        wr_en;

  typedef struct packed {
    logic [13:0] a;
    logic [15:0] d;
    logic [1:0]  be;
  } wr_t;

  wr_t         exp_q [$];
  wr_t         mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [13:0] exp_wr;

  always #5 clk = ~clk;

  tx_slot_arbiter dut (
    .gmii_tx_clk        (clk),
    .sys_rst            (sys_rst),
    .req0_valid         (vld[0]),
    .req0_data          (dat[0]),
    .req0_sof           (sof[0]),
    .req0_eof           (eof[0]),
    .req0_ready         (rdy[0]),
    .req1_valid         (vld[1]),
    .req1_data          (dat[1]),
    .req1_sof           (sof[1]),
    .req1_eof           (eof[1]),
    .req1_ready         (rdy[1]),
    .mem_rd_ptr         (mem_rd_ptr),
    .mem_wr_ptr         (mem_wr_ptr),
    .slot_tx_eth_addr   (wr_addr),
    .slot_tx_eth_data   (wr_data),
    .slot_tx_eth_byte_en(wr_be),
    .slot_tx_eth_wr_en  (wr_en),
    .grant              (grant),
    .drop_count         (drop_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!sys_rst && wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0h data %0h, none expected", wr_addr, wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(mon_e.a));
        check("wr_data", 32'(wr_data), 32'(mon_e.d));
        check("wr_be", 32'(wr_be), 32'(mon_e.be));
      end
    end
  end

  // Drives nwords of a record on port p; accepted words of a well-formed length are
  // expected in RAM at base+i.
  task automatic send(input int p, input int len, input int nwords, input bit with_eof,
                      input logic [13:0] base);
    int          w;
    int          waitc;
    bit          wr_ok;
    bit          acc;
    logic [15:0] word;
    wr_t         e;
    w     = 7 + (len + 1) / 2;
    wr_ok = (len >= 60) && (len <= 1514);
    for (int i = 0; i < nwords; i++) begin
      word = (i == 0) ? 16'(len) : {3'b101, 1'(p), 12'(i)};
      @(negedge clk);
      vld[p] = 1'b1;
      dat[p] = word;
      sof[p] = (i == 0);
      eof[p] = with_eof && (i == nwords - 1);
      waitc  = 0;
      acc    = 1'b0;
      while (!acc) begin
        #4;
        acc = rdy[p];
        @(posedge clk);
        if (!acc) begin
          waitc++;
          if (waitc > 3000) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: port %0d word %0d got no ready, required ready", p, i);
            vld[p] = 1'b0;
            return;
          end
          @(negedge clk);
        end
      end
      if (wr_ok) begin
        e.a  = 14'(base + 14'(i));
        e.d  = word;
        e.be = (i == w - 1 && (len % 2) == 1) ? 2'b10 : 2'b11;
        exp_q.push_back(e);
      end
    end
    @(negedge clk);
    vld[p] = 1'b0;
    sof[p] = 1'b0;
    eof[p] = 1'b0;
  endtask

  // Returns at the negedge after the last accept: commit must land one cycle later.
  task automatic check_commit(input string name, input logic [13:0] old_ptr,
                              input logic [13:0] new_ptr);
    check({name, "_hold"}, 32'(mem_wr_ptr), 32'(old_ptr));
    @(negedge clk);
    check(name, 32'(mem_wr_ptr), 32'(new_ptr));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int rem;
    int w;
    int k;
    sys_rst    = 1'b1;
    vld        = '0;
    sof        = '0;
    eof        = '0;
    dat[0]     = '0;
    dat[1]     = '0;
    mem_rd_ptr = '0;
    repeat (3) @(negedge clk);
    sys_rst = 1'b0;
    @(negedge clk);
    check("rst_wr_ptr", 32'(mem_wr_ptr), 0);
    check("rst_grant", 32'(grant), 0);
    check("rst_drop", 32'(drop_count), 0);
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_ready", 32'(rdy), 0);

    // 1: single len=60 record into an empty ring
    send(0, 60, 37, 1'b1, 14'h0000);
    check_commit("t1_ptr", 14'h0000, 14'h0025);

    // 2: simultaneous sof after reset, req0 wins the first tie
    @(negedge clk) sys_rst = 1'b1;
    @(negedge clk) sys_rst = 1'b0;
    check("t2_rst_ptr", 32'(mem_wr_ptr), 0);
    fork
      send(0, 61, 38, 1'b1, 14'h0000);
      send(1, 61, 38, 1'b1, 14'h0026);
      begin
        @(negedge clk);
        @(negedge clk);
        check("t2_grant_first", 32'(grant), 32'h1);
      end
    join
    @(negedge clk);
    check("t2_ptr", 32'(mem_wr_ptr), 32'h004C);
    exp_wr = 14'h004C;

    // 4: insufficient space holds LEN until mem_rd_ptr advances
    mem_rd_ptr = exp_wr + 14'd20;
    fork
      send(0, 100, 57, 1'b1, exp_wr);
      begin
        @(negedge clk);
        repeat (8) begin
          @(negedge clk);
          check("t4_hold_ready", 32'(rdy[0]), 0);
          check("t4_hold_wr_en", 32'(wr_en), 0);
        end
        mem_rd_ptr = mem_rd_ptr + 14'd64;
      end
    join
    check_commit("t4_ptr", exp_wr, exp_wr + 14'd57);
    exp_wr = exp_wr + 14'd57;

    // 5: oversized record dropped, then a truncated record dropped
    mem_rd_ptr = exp_wr;
    send(1, 2000, 20, 1'b1, exp_wr);
    check("t5_drop1", 32'(drop_count), 1);
    check("t5_ptr1", 32'(mem_wr_ptr), 32'(exp_wr));
    send(0, 60, 10, 1'b1, exp_wr);
    check("t5_drop2", 32'(drop_count), 2);
    @(negedge clk);
    @(negedge clk);
    check("t5_ptr2", 32'(mem_wr_ptr), 32'(exp_wr));

    // Stray words without sof in IDLE are consumed silently
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vld[1] = 1'b1;
      sof[1] = 1'b0;
      dat[1] = 16'hDEAD;
      #4;
      check("idle_discard_ready", 32'(rdy[1]), 1);
    end
    @(negedge clk);
    vld[1] = 1'b0;
    @(negedge clk);
    check("idle_discard_drop", 32'(drop_count), 2);

    // Fill the ring up to 0x3FF0 with committed records
    k = 0;
    while (exp_wr != 14'h3FF0) begin
      rem = 16'h3FF0 - int'(exp_wr);
      w = (rem > 800) ? 764 : ((rem > 764) ? rem / 2 : rem);
      mem_rd_ptr = exp_wr;
      send(k % 2, (w - 7) * 2, w, 1'b1, exp_wr);
      @(negedge clk);
      exp_wr = exp_wr + 14'(w);
      k++;
    end
    check("fill_ptr", 32'(mem_wr_ptr), 32'h3FF0);

    // 3: record straddling the top of the ring
    mem_rd_ptr = 14'h3FF0;
    send(0, 64, 39, 1'b1, 14'h3FF0);
    check_commit("t3_ptr", 14'h3FF0, 14'h0017);

    // 6: asynchronous reset mid-WRITE
    mem_rd_ptr = 14'h0017;
    send(1, 60, 10, 1'b0, 14'h0017);
    #2 sys_rst = 1'b1;
    #1;
    check("t6_wr_en", 32'(wr_en), 0);
    check("t6_addr", 32'(wr_addr), 0);
    check("t6_data", 32'(wr_data), 0);
    check("t6_ptr", 32'(mem_wr_ptr), 0);
    check("t6_grant", 32'(grant), 0);
    check("t6_drop", 32'(drop_count), 0);
    @(negedge clk) sys_rst = 1'b0;
    mem_rd_ptr = 14'h0000;
    send(0, 60, 37, 1'b1, 14'h0000);
    check_commit("t6_ptr_after", 14'h0000, 14'h0025);

    @(negedge clk);
    check("sb_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
